// File: rtl/cpu_bridge_pkg.sv
// Shared types and constants for the CPU register-bus bridge.
package cpu_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    localparam logic [31:0] ERR_DATA_DFLT = 32'h0000_DEAD;

endpackage

// File: rtl/cpu_bridge_timer.sv
// Request watchdog: counts cycles while enabled; expired flags the cycle in
// which the count would reach TIMEOUT, so the FSM can leave REQ on that edge.
module cpu_bridge_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic cpu_clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en && count_q != LAST)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign expired = en && (count_q == LAST);

endmodule

// File: rtl/cpu_bus_bridge.sv
// CPU bus to N_TGT register targets: address decode, one-hot req/ack
// handshake with timeout, and registered read data / ack / error back to the CPU.
module cpu_bus_bridge
    import cpu_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 16,
    parameter int N_TGT   = 4,
    parameter int TGT_AW  = 12,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DFLT)
) (
    input  logic                      cpu_clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         cpu_addr,
    input  logic                      cpu_cs,
    input  logic                      cpu_wr,
    input  logic                      cpu_rd,
    input  logic [DATA_W-1:0]         cpu_data_in,
    output logic [DATA_W-1:0]         cpu_data_out,
    output logic                      cpu_ack,
    output logic                      cpu_err,
    output logic [N_TGT-1:0]          tgt_req,
    output logic                      tgt_wr,
    output logic [TGT_AW-1:0]         tgt_addr,
    output logic [DATA_W-1:0]         tgt_wdata,
    input  logic [N_TGT-1:0]          tgt_ack,
    input  logic [N_TGT*DATA_W-1:0]   tgt_rdata
);
    localparam int IDXW = (N_TGT > 1) ? $clog2(N_TGT) : 1;

    state_e              state_q, state_d;
    logic [N_TGT-1:0]    req_q, req_d;
    logic                wr_q, wr_d;
    logic [TGT_AW-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                cs_q, cs_d;
    logic                armed_q, armed_d;

    logic [IDXW-1:0]     start_idx;
    logic                upper_bad, idx_bad, strobe_bad, dec_err, start;
    logic                ack_hit, expired;
    logic [DATA_W-1:0]   sel_rdata;
    logic [DATA_W-1:0]   rdata_arr [N_TGT];

    assign start_idx = cpu_addr[TGT_AW +: IDXW];

    generate
        if (ADDR_W > TGT_AW + IDXW) begin : g_upper
            assign upper_bad = |cpu_addr[ADDR_W-1:TGT_AW+IDXW];
        end else begin : g_no_upper
            assign upper_bad = 1'b0;
        end
        for (genvar gi = 0; gi < N_TGT; gi++) begin : g_rdata
            assign rdata_arr[gi] = tgt_rdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign idx_bad    = 32'(start_idx) >= N_TGT;
    assign strobe_bad = (cpu_wr == cpu_rd);
    assign dec_err    = upper_bad || idx_bad || strobe_bad;
    // armed_q blocks a cs held high across reset release from starting an access.
    assign start      = cpu_cs && !cs_q && armed_q;

    // req_q is one-hot on the selected target, so it doubles as the ack/data select.
    assign ack_hit = |(tgt_ack & req_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_TGT; i++) begin
            if (req_q[i])
                sel_rdata = sel_rdata | rdata_arr[i];
        end
    end

    cpu_bridge_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .clr     (state_q != REQ),
        .en      (state_q == REQ),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        dout_d  = dout_q;
        cs_d    = cpu_cs;
        armed_d = armed_q | ~cpu_cs;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wr_d    = cpu_wr;
                    addr_d  = cpu_addr[TGT_AW-1:0];
                    wdata_d = cpu_data_in;
                    if (dec_err) begin
                        state_d = ERR;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        dout_d  = ERR_DATA;
                    end else begin
                        state_d = REQ;
                        req_d   = N_TGT'(1) << start_idx;
                    end
                end
            end
            REQ: begin
                // Ack beats a timeout landing on the same edge.
                if (ack_hit) begin
                    state_d = DONE;
                    req_d   = '0;
                    ack_d   = 1'b1;
                    err_d   = 1'b0;
                    dout_d  = wr_q ? '0 : sel_rdata;
                end else if (expired) begin
                    state_d = ERR;
                    req_d   = '0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    dout_d  = ERR_DATA;
                end
            end
            DONE, ERR: begin
                if (!cpu_cs) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    dout_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            cs_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            cs_q    <= cs_d;
            armed_q <= armed_d;
        end
    end

    assign tgt_req      = req_q;
    assign tgt_wr       = wr_q;
    assign tgt_addr     = addr_q;
    assign tgt_wdata    = wdata_q;
    assign cpu_ack      = ack_q;
    assign cpu_err      = err_q;
    assign cpu_data_out = dout_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge with TIMEOUT=8; inputs change and outputs
// are checked 1 ns after each rising edge.
module tb_cpu_bus_bridge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int N_TGT  = 4;
    localparam int TGT_AW = 12;

    logic                    cpu_clk = 1'b0;
    logic                    rst = 1'b1;
    logic [ADDR_W-1:0]       cpu_addr = '0;
    logic                    cpu_cs = 1'b0;
    logic                    cpu_wr = 1'b0;
    logic                    cpu_rd = 1'b0;
    logic [DATA_W-1:0]       cpu_data_in = '0;
    logic [DATA_W-1:0]       cpu_data_out;
    logic                    cpu_ack;
    logic                    cpu_err;
    logic [N_TGT-1:0]        tgt_req;
    logic                    tgt_wr;
    logic [TGT_AW-1:0]       tgt_addr;
    logic [DATA_W-1:0]       tgt_wdata;
    logic [N_TGT-1:0]        tgt_ack = '0;
    logic [N_TGT*DATA_W-1:0] tgt_rdata = {N_TGT{16'hFFFF}};

    int checks = 0;
    int passed = 0;

    cpu_bus_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_TGT(N_TGT),
        .TGT_AW(TGT_AW), .TIMEOUT(8)
    ) dut (
        .cpu_clk      (cpu_clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_cs       (cpu_cs),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_ack      (cpu_ack),
        .cpu_err      (cpu_err),
        .tgt_req      (tgt_req),
        .tgt_wr       (tgt_wr),
        .tgt_addr     (tgt_addr),
        .tgt_wdata    (tgt_wdata),
        .tgt_ack      (tgt_ack),
        .tgt_rdata    (tgt_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
            $display("check %-16s obs=%0h exp=%0h", tag, obs, exp);
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_access(input logic [31:0] addr, input logic wr, input logic rd,
                                input logic [15:0] wdata);
        cpu_addr    = addr;
        cpu_wr      = wr;
        cpu_rd      = rd;
        cpu_data_in = wdata;
        cpu_cs      = 1'b1;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check("rst_req",   32'(tgt_req), 32'h0);
        check("rst_ack",   32'(cpu_ack), 32'h0);
        check("rst_err",   32'(cpu_err), 32'h0);
        check("rst_data",  32'(cpu_data_out), 32'h0);
        check("rst_wr",    32'(tgt_wr), 32'h0);
        check("rst_addr",  32'(tgt_addr), 32'h0);
        check("rst_wdata", 32'(tgt_wdata), 32'h0);
        rst = 1'b0;
        tick(); tick();

        // Read target 2, three wait cycles, stray ack on target 0 ignored
        start_access(32'h2010, 1'b0, 1'b1, 16'h0);
        tick();
        check("rd_req",    32'(tgt_req), 32'h4);
        check("rd_addr",   32'(tgt_addr), 32'h010);
        check("rd_wr",     32'(tgt_wr), 32'h0);
        check("rd_ack0",   32'(cpu_ack), 32'h0);
        tgt_ack = 4'b0001;
        tick();
        tgt_ack = 4'b0000;
        check("rd_stray",  32'(tgt_req), 32'h4);
        check("rd_stray_a", 32'(cpu_ack), 32'h0);
        tick(); tick();
        tgt_ack = 4'b0100;
        tgt_rdata[2*DATA_W +: DATA_W] = 16'h1234;
        tick();
        tgt_ack = 4'b0000;
        check("rd_req_off", 32'(tgt_req), 32'h0);
        check("rd_ack",     32'(cpu_ack), 32'h1);
        check("rd_err",     32'(cpu_err), 32'h0);
        check("rd_data",    32'(cpu_data_out), 32'h1234);
        cpu_cs = 1'b0;
        tick();
        check("rd_ack_off", 32'(cpu_ack), 32'h0);
        check("rd_data_clr", 32'(cpu_data_out), 32'h0);

        // Write to target 0 with immediate ack; read data on the bus is ignored
        start_access(32'h0004, 1'b1, 1'b0, 16'hA5A5);
        tick();
        check("wr_req",    32'(tgt_req), 32'h1);
        check("wr_wr",     32'(tgt_wr), 32'h1);
        check("wr_wdata",  32'(tgt_wdata), 32'hA5A5);
        check("wr_addr",   32'(tgt_addr), 32'h004);
        check("wr_ack0",   32'(cpu_ack), 32'h0);
        tgt_ack = 4'b0001;
        tgt_rdata[0 +: DATA_W] = 16'h5555;
        tick();
        tgt_ack = 4'b0000;
        check("wr_ack",    32'(cpu_ack), 32'h1);
        check("wr_err",    32'(cpu_err), 32'h0);
        check("wr_data",   32'(cpu_data_out), 32'h0);
        cpu_cs = 1'b0;
        tick();

        // Decode errors: upper address bits, then both strobes
        start_access(32'h1_0000, 1'b0, 1'b1, 16'h0);
        tick();
        check("up_req",    32'(tgt_req), 32'h0);
        check("up_ack",    32'(cpu_ack), 32'h1);
        check("up_err",    32'(cpu_err), 32'h1);
        check("up_data",   32'(cpu_data_out), 32'hDEAD);
        cpu_cs = 1'b0;
        tick();
        check("up_ack_off", 32'(cpu_ack), 32'h0);
        check("up_err_off", 32'(cpu_err), 32'h0);
        start_access(32'h1000, 1'b1, 1'b1, 16'h0);
        tick();
        check("strb_req",  32'(tgt_req), 32'h0);
        check("strb_ack",  32'(cpu_ack), 32'h1);
        check("strb_err",  32'(cpu_err), 32'h1);
        cpu_cs = 1'b0;
        tick();

        // Timeout: request held exactly 8 cycles
        start_access(32'h3000, 1'b0, 1'b1, 16'h0);
        tick();
        check("to_req",    32'(tgt_req), 32'h8);
        for (int i = 0; i < 7; i++) tick();
        check("to_req7",   32'(tgt_req), 32'h8);
        check("to_ack7",   32'(cpu_ack), 32'h0);
        tick();
        check("to_req_off", 32'(tgt_req), 32'h0);
        check("to_ack",    32'(cpu_ack), 32'h1);
        check("to_err",    32'(cpu_err), 32'h1);
        check("to_data",   32'(cpu_data_out), 32'hDEAD);
        cpu_cs = 1'b0;
        tick();

        // Ack arriving in the eighth request cycle wins over timeout
        start_access(32'h3000, 1'b0, 1'b1, 16'h0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        tgt_ack = 4'b1000;
        tgt_rdata[3*DATA_W +: DATA_W] = 16'hBEEF;
        tick();
        tgt_ack = 4'b0000;
        check("late_ack",  32'(cpu_ack), 32'h1);
        check("late_err",  32'(cpu_err), 32'h0);
        check("late_data", 32'(cpu_data_out), 32'hBEEF);
        cpu_cs = 1'b0;
        tick();

        // cs dropped and re-raised during REQ; ack later gives a one-cycle DONE
        start_access(32'h1000, 1'b0, 1'b1, 16'h0);
        tick();
        cpu_cs = 1'b0;
        tick();
        cpu_cs = 1'b1;
        cpu_addr = 32'h2000;
        tick();
        check("cs_rerise_req", 32'(tgt_req), 32'h2);
        cpu_cs = 1'b0;
        tick();
        tgt_ack = 4'b0010;
        tgt_rdata[1*DATA_W +: DATA_W] = 16'h0BAD;
        tick();
        tgt_ack = 4'b0000;
        check("drop_ack",  32'(cpu_ack), 32'h1);
        check("drop_data", 32'(cpu_data_out), 32'h0BAD);
        tick();
        check("drop_pulse", 32'(cpu_ack), 32'h0);
        tick();
        check("drop_idle", 32'(tgt_req), 32'h0);

        // Asynchronous reset mid-request; cs held high across release
        start_access(32'h2000, 1'b0, 1'b1, 16'h0);
        tick();
        check("rr_req",    32'(tgt_req), 32'h4);
        rst = 1'b1;
        #1;
        check("rr_req_async", 32'(tgt_req), 32'h0);
        check("rr_ack_async", 32'(cpu_ack), 32'h0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("rr_no_start", 32'(tgt_req), 32'h0);
        cpu_cs = 1'b0;
        tick();
        cpu_cs = 1'b1;
        tick();
        check("rr_restart", 32'(tgt_req), 32'h4);
        tgt_ack = 4'b0100;
        tgt_rdata[2*DATA_W +: DATA_W] = 16'h4321;
        tick();
        tgt_ack = 4'b0000;
        check("rr_data",   32'(cpu_data_out), 32'h4321);
        cpu_cs = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_bridge.md
# cpu_bus_bridge

Parametrised CPU register-bus bridge. It sits between the CPU bus master (`cpu_addr`/`cpu_cs`/`cpu_wr`/`cpu_rd`) and `N_TGT` register targets. It decodes each access to one target and runs a req/ack handshake with that target. It then returns read data with an explicit `cpu_ack`, adding configurable width, target count, timeout and error signalling.

## Interface
- ADDR_W, 32, CPU address width.
- DATA_W, 16, data width of CPU and target buses.
- N_TGT, 4, number of targets (≥1).
- TGT_AW, 12, per-target word-offset width; each target window is 2^TGT_AW words.
- TIMEOUT, 255, maximum cycles `tgt_req` stays high without `tgt_ack` (≥1).
- ERR_DATA, 'hDEAD (truncated to DATA_W), read data returned on any error.
- IDXW (derived, localparam), max(1, $clog2(N_TGT)).

Ports:
- cpu_clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  ADDR_W  access address.
- cpu_cs  in  1  chip select, active high; an access is its rising edge.
- cpu_wr  in  1  write strobe, valid with cs.
- cpu_rd  in  1  read strobe, valid with cs.
- cpu_data_in  in  DATA_W  write data.
- cpu_data_out  out  DATA_W  read data, valid while cpu_ack=1.
- cpu_ack  out  1  access complete; held until cpu_cs low.
- cpu_err  out  1  qualifies cpu_ack: decode error, illegal strobe or timeout.
- tgt_req  out  N_TGT  one-hot request, held until ack or timeout.
- tgt_wr  out  1  1=write, 0=read; stable while any tgt_req.
- tgt_addr  out  TGT_AW  word offset within target.
- tgt_wdata  out  DATA_W  write data.
- tgt_ack  in  N_TGT  per-target single-cycle completion pulse.
- tgt_rdata  in  N_TGT*DATA_W  read data, slice i valid with tgt_ack[i].

## Operation
- FSM states: IDLE, REQ, DONE, ERR. All outputs are registered.
- Reset values: state=IDLE, tgt_req=0, tgt_wr=0, tgt_addr=0, tgt_wdata=0, cpu_ack=0, cpu_err=0, cpu_data_out=0, timer=0, cs_q=0.
- Start condition: cpu_cs=1 and cs_q=0 (cs_q = cpu_cs registered), sampled in IDLE only. A cs rise outside IDLE is ignored.
- Latch on start: idx=cpu_addr[TGT_AW +: IDXW], offset=cpu_addr[TGT_AW-1:0], wr=cpu_wr, data_in.
- Decode error if any of the following holds:
  - cpu_addr[ADDR_W-1 : TGT_AW+IDXW] is nonzero;
  - idx ≥ N_TGT;
  - cpu_wr == cpu_rd (both or neither).
- IDLE→ERR on decode error; IDLE→REQ otherwise.
- REQ: tgt_req[idx]=1; timer increments each cycle.
  - On tgt_ack[idx]=1: capture tgt_rdata slice (writes capture 0) and go to DONE.
  - If timer reaches TIMEOUT first: go to ERR.
  - tgt_ack on a non-selected bit is ignored.
- DONE: cpu_ack=1, cpu_err=0, cpu_data_out=captured data. Exit to IDLE when cpu_cs=0.
- ERR: cpu_ack=1, cpu_err=1, cpu_data_out=ERR_DATA. Exit to IDLE when cpu_cs=0.
- cpu_cs dropping during REQ does not abort the target handshake. DONE/ERR is still entered and lasts exactly one cycle.
- On entering IDLE, cpu_ack, cpu_err and cpu_data_out clear to 0.

## Timing
- cs rise sampled at edge N: tgt_req high from edge N+1.
- tgt_ack sampled at edge M: tgt_req low and cpu_ack high from edge M+1. This gives a zero-wait target a 3-cycle cs-to-ack latency.
- Timeout: with no ack, tgt_req is high for exactly TIMEOUT cycles, then cpu_ack/cpu_err assert the next cycle.
- tgt_ack in the same cycle the timer reaches TIMEOUT: ack wins, no error.
- cpu_ack falls one cycle after cpu_cs is sampled low.
- Back-to-back accesses need cs low for ≥1 sampled cycle between them.
- rst asserted mid-access drops tgt_req and cpu_ack immediately (asynchronous) and returns to IDLE. A cs still high at release does not start a new access until it falls and rises again.

## Structure
- `cpu_bridge_pkg`: state enum (IDLE, REQ, DONE, ERR) and the ERR_DATA default constant.
- One sub-module, `cpu_bridge_timer`: a $clog2(TIMEOUT+1)-bit counter with clear/enable inputs and an `expired` output.
- Target read-data mux and decode stay inline in the top module.

## Test plan
- Read, target 2 (addr 0x2010), tgt_ack after 3 wait cycles with rdata 0x1234 → tgt_req=4'b0100, tgt_addr=0x010, cpu_data_out=0x1234, cpu_err=0.
- Write 0xA5A5 to addr 0x0004, immediate ack → tgt_wr=1, tgt_wdata=0xA5A5, cpu_ack 3 cycles after cs rise, cpu_data_out=0.
- Access addr 0x10000 (upper bits set), and separately cs with wr=rd=1 → no tgt_req; cpu_ack=1, cpu_err=1, data=0xDEAD.
- TIMEOUT=8, target never acks → tgt_req high exactly 8 cycles, then cpu_err=1, data=0xDEAD. A separate case with ack on cycle 8 → no error.
- cs dropped during REQ, ack later → one-cycle DONE pulse, then IDLE. A second cs rise during REQ is ignored.
- rst pulsed during REQ → all outputs 0 immediately. cs held high across release → no new tgt_req until cs toggles.
